// File: rtl/escr_rtc.sv
// escr_rtc: write controller for the RTC multiplexed address/data bus.
// On an escribir request it snapshots nine BCD bytes and issues one
// address-phase/data-phase write transaction per register.
// Optional feature: define RTC_WR_COMMIT_EN to append a tenth transaction
// (address 0xF1, data 0x00) that commits the new time into the RTC.
module escr_rtc #(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 4,
    parameter int T_HOLD  = 2,
    parameter int T_GAP   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       escribir,
    input  logic [7:0] seg,
    input  logic [7:0] min,
    input  logic [7:0] hora,
    input  logic [7:0] dia,
    input  logic [7:0] mes,
    input  logic [7:0] anio,
    input  logic [7:0] tseg,
    input  logic [7:0] tmin,
    input  logic [7:0] thora,
    output logic       a_d,
    output logic       cs,
    output logic       rd,
    output logic       wr,
    output logic [7:0] dato_out,
    output logic       buffer_activo,
    output logic       ocupado,
    output logic       ready
);

    localparam int MAX_AB = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int MAX_CD = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = (MAX_P > 1) ? $clog2(MAX_P + 1) : 1;

    localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_PULSE = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LD_GAP   = CW'(T_GAP - 1);

`ifdef RTC_WR_COMMIT_EN
    localparam logic [3:0] LAST_IDX = 4'd9;
`else
    localparam logic [3:0] LAST_IDX = 4'd8;
`endif

    typedef enum logic [3:0] {
        IDLE, A_SET, A_WR, A_HOLD, A_GAP, D_SET, D_WR, D_HOLD, D_GAP, DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    idx;
    logic [7:0]    snap [9];
    logic [3:0]    idx_next;
    logic [7:0]    addr_next;
    logic [7:0]    data_cur;

    assign rd = 1'b1;

    // Address of the following item and data of the current item.
    always_comb begin
        idx_next  = idx + 4'd1;
        addr_next = 8'h00;
        data_cur  = 8'h00;
        case (idx_next)
            4'd0: addr_next = 8'h21;
            4'd1: addr_next = 8'h22;
            4'd2: addr_next = 8'h23;
            4'd3: addr_next = 8'h24;
            4'd4: addr_next = 8'h25;
            4'd5: addr_next = 8'h26;
            4'd6: addr_next = 8'h41;
            4'd7: addr_next = 8'h42;
            4'd8: addr_next = 8'h43;
`ifdef RTC_WR_COMMIT_EN
            4'd9: addr_next = 8'hF1;
`endif
            default: addr_next = 8'h00;
        endcase
        case (idx)
            4'd0: data_cur = snap[0];
            4'd1: data_cur = snap[1];
            4'd2: data_cur = snap[2];
            4'd3: data_cur = snap[3];
            4'd4: data_cur = snap[4];
            4'd5: data_cur = snap[5];
            4'd6: data_cur = snap[6];
            4'd7: data_cur = snap[7];
            4'd8: data_cur = snap[8];
            default: data_cur = 8'h00;
        endcase
    end

    // Sequencer: shared down-counter times every state; outputs are set on
    // the edge entering each state so they are glitch-free registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            for (int unsigned i = 0; i < 9; i++) snap[i] <= '0;
            a_d           <= 1'b1;
            cs            <= 1'b1;
            wr            <= 1'b1;
            dato_out      <= '0;
            buffer_activo <= 1'b0;
            ocupado       <= 1'b0;
            ready         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    if (escribir) begin
                        snap[0]       <= seg;
                        snap[1]       <= min;
                        snap[2]       <= hora;
                        snap[3]       <= dia;
                        snap[4]       <= mes;
                        snap[5]       <= anio;
                        snap[6]       <= tseg;
                        snap[7]       <= tmin;
                        snap[8]       <= thora;
                        idx           <= '0;
                        ocupado       <= 1'b1;
                        cnt           <= LD_SETUP;
                        cs            <= 1'b0;
                        a_d           <= 1'b0;
                        buffer_activo <= 1'b1;
                        dato_out      <= 8'h21;
                        state         <= A_SET;
                    end
                end
                A_SET, D_SET: begin
                    if (cnt == '0) begin
                        cnt   <= LD_PULSE;
                        wr    <= 1'b0;
                        state <= (state == A_SET) ? A_WR : D_WR;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                A_WR, D_WR: begin
                    if (cnt == '0) begin
                        cnt   <= LD_HOLD;
                        wr    <= 1'b1;
                        state <= (state == A_WR) ? A_HOLD : D_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                A_HOLD, D_HOLD: begin
                    if (cnt == '0) begin
                        cnt           <= LD_GAP;
                        cs            <= 1'b1;
                        a_d           <= 1'b1;
                        buffer_activo <= 1'b0;
                        state         <= (state == A_HOLD) ? A_GAP : D_GAP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                A_GAP: begin
                    if (cnt == '0) begin
                        cnt           <= LD_SETUP;
                        cs            <= 1'b0;
                        buffer_activo <= 1'b1;
                        dato_out      <= data_cur;
                        state         <= D_SET;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                D_GAP: begin
                    if (cnt == '0) begin
                        if (idx == LAST_IDX) begin
                            ready <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx           <= idx_next;
                            cnt           <= LD_SETUP;
                            cs            <= 1'b0;
                            a_d           <= 1'b0;
                            buffer_activo <= 1'b1;
                            dato_out      <= addr_next;
                            state         <= A_SET;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    ready   <= 1'b0;
                    ocupado <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_escr_rtc.sv
// Scoreboard bench for escr_rtc: stimulus pushes expected address/data pairs
// and completion cycles; a bus monitor pops and compares them.
module tb_escr_rtc;

    localparam int TS = 2, TP = 4, TH = 2, TG = 2;
    localparam int TX = 2 * (TS + TP + TH + TG);
`ifdef RTC_WR_COMMIT_EN
    localparam int N = 10;
`else
    localparam int N = 9;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       escribir = 1'b0;
    logic [7:0] seg = '0, min = '0, hora = '0, dia = '0, mes = '0;
    logic [7:0] anio = '0, tseg = '0, tmin = '0, thora = '0;
    logic       a_d, cs, rd, wr, buffer_activo, ocupado, ready;
    logic [7:0] dato_out;

    escr_rtc #(.T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_GAP(TG)) dut (
        .clk(clk), .reset(reset), .escribir(escribir),
        .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes), .anio(anio),
        .tseg(tseg), .tmin(tmin), .thora(thora),
        .a_d(a_d), .cs(cs), .rd(rd), .wr(wr), .dato_out(dato_out),
        .buffer_activo(buffer_activo), .ocupado(ocupado), .ready(ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int dphase_cnt = 0;
    logic [15:0] exp_q [$];
    int          rdy_q [$];
    int          first_wr_exp = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor state
    logic       wr_p = 1'b1, cs_p = 1'b1, have_addr = 1'b0;
    logic [7:0] got_addr = '0, win_d = '0;
    logic       win_ad = 1'b0, win_err = 1'b0, prot_err = 1'b0;
    int         wl = 0;

    always @(negedge clk) begin
        if (reset) begin
            wr_p = 1'b1; cs_p = 1'b1; have_addr = 1'b0; wl = 0;
            win_err = 1'b0; prot_err = 1'b0;
        end else begin
            if (cs === 1'b1 && (buffer_activo !== 1'b0 || rd !== 1'b1)) prot_err = 1'b1;
            if (rd !== 1'b1) prot_err = 1'b1;
            // wr falling: capture phase
            if (wr === 1'b0 && wr_p === 1'b1) begin
                wl = 1;
                if (a_d === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_txn addr=%02h cyc=%0d", dato_out, cyc);
                    end
                    got_addr = dato_out; have_addr = 1'b1;
                    if (first_wr_exp >= 0) begin
                        checks++;
                        if (cyc != first_wr_exp) begin
                            failures++;
                            $display("FAIL first_wr_cycle got=%0d exp=%0d", cyc, first_wr_exp);
                        end
                        first_wr_exp = -1;
                    end
                end else begin
                    dphase_cnt++;
                    checks++;
                    if (!have_addr || exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL data_without_addr data=%02h", dato_out);
                    end else begin
                        logic [15:0] e;
                        e = exp_q.pop_front();
                        if ({got_addr, dato_out} !== e) begin
                            failures++;
                            $display("FAIL pair got=%02h/%02h exp=%02h/%02h",
                                     got_addr, dato_out, e[15:8], e[7:0]);
                        end
                    end
                    have_addr = 1'b0;
                end
            end else if (wr === 1'b0) begin
                wl++;
            end else if (wr === 1'b1 && wr_p === 1'b0) begin
                checks++;
                if (wl != TP) begin
                    failures++;
                    $display("FAIL wr_low_len got=%0d exp=%0d", wl, TP);
                end
            end
            // cs window stability
            if (cs === 1'b0 && cs_p === 1'b1) begin
                win_d = dato_out; win_ad = a_d; win_err = 1'b0;
            end
            if (cs === 1'b0) begin
                if (dato_out !== win_d || a_d !== win_ad || buffer_activo !== 1'b1 || ocupado !== 1'b1)
                    win_err = 1'b1;
            end else if (cs === 1'b1 && cs_p === 1'b0) begin
                checks++;
                if (win_err) begin
                    failures++;
                    $display("FAIL cs_window_stable got=unstable exp=stable data=%02h", win_d);
                end
            end
            // completion pulse
            if (ready === 1'b1) begin
                checks++;
                if (rdy_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_ready cyc=%0d", cyc);
                end else begin
                    int er;
                    er = rdy_q.pop_front();
                    if (cyc != er || exp_q.size() != 0 || prot_err) begin
                        failures++;
                        $display("FAIL ready got_cyc=%0d exp_cyc=%0d pending=%0d prot_err=%0b",
                                 cyc, er, exp_q.size(), prot_err);
                    end
                end
                prot_err = 1'b0;
                done_cnt++;
            end
            wr_p = wr; cs_p = cs;
        end
    end

    function automatic logic [7:0] rbcd();
        logic [3:0] hi, lo;
        hi = 4'($urandom_range(0, 9));
        lo = 4'($urandom_range(0, 9));
        return {hi, lo};
    endfunction

    task automatic scramble();
        seg = 8'($urandom); min = 8'($urandom); hora = 8'($urandom);
        dia = 8'($urandom); mes = 8'($urandom); anio = 8'($urandom);
        tseg = 8'($urandom); tmin = 8'($urandom); thora = 8'($urandom);
    endtask

    task automatic push_expected();
        exp_q.push_back({8'h21, seg});  exp_q.push_back({8'h22, min});
        exp_q.push_back({8'h23, hora}); exp_q.push_back({8'h24, dia});
        exp_q.push_back({8'h25, mes});  exp_q.push_back({8'h26, anio});
        exp_q.push_back({8'h41, tseg}); exp_q.push_back({8'h42, tmin});
        exp_q.push_back({8'h43, thora});
        if (N == 10) exp_q.push_back({8'hF1, 8'h00});
    endtask

    // Issue a start at the next edge k (= cyc+1); cs low from cycle k,
    // first wr low at k+TS, ready at k+N*TX.
    task automatic issue_start();
        @(negedge clk);
        escribir = 1'b1;
        push_expected();
        first_wr_exp = cyc + 1 + TS;
        rdy_q.push_back(cyc + 1 + N * TX);
        @(negedge clk);
        checks++;
        if (cs !== 1'b0 || a_d !== 1'b0 || dato_out !== 8'h21 || ocupado !== 1'b1) begin
            failures++;
            $display("FAIL start_latency cs=%0b a_d=%0b data=%02h ocupado=%0b exp=0/0/21/1",
                     cs, a_d, dato_out, ocupado);
        end
    endtask

    task automatic wait_done(input int d0);
        int t;
        t = 0;
        while (done_cnt == d0 && t < N * TX + 100) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == d0) begin
            checks++; failures++;
            $display("FAIL timeout_ready got=none exp=pulse");
        end
        @(negedge clk);
        checks++;
        if (ocupado !== 1'b0 || ready !== 1'b0) begin
            failures++;
            $display("FAIL post_done ocupado=%0b ready=%0b exp=0/0", ocupado, ready);
        end
    endtask

    task automatic xfer(input bit hold_req);
        int d0;
        d0 = done_cnt;
        seg = rbcd(); min = rbcd(); hora = rbcd(); dia = rbcd(); mes = rbcd();
        anio = rbcd(); tseg = rbcd(); tmin = rbcd(); thora = rbcd();
        issue_start();
        if (hold_req) begin
            for (int j = 0; j < N * TX - 4; j++) begin
                scramble();
                escribir = 1'b1;
                @(negedge clk);
            end
        end
        escribir = 1'b0;
        wait_done(d0);
    endtask

    initial begin
        // reset and idle check
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({a_d, cs, rd, wr, dato_out, buffer_activo, ocupado, ready} !== {4'b1111, 8'h00, 3'b000}) begin
                failures++;
                $display("FAIL idle_reset_vals got=%b%b%b%b/%02h/%b%b%b exp=1111/00/000",
                         a_d, cs, rd, wr, dato_out, buffer_activo, ocupado, ready);
            end
        end

        // directed transfer from the example values
        begin
            int d0;
            d0 = done_cnt;
            seg = 8'h45; min = 8'h30; hora = 8'h12; dia = 8'h07; mes = 8'h11;
            anio = 8'h16; tseg = 8'h10; tmin = 8'h05; thora = 8'h01;
            issue_start();
            escribir = 1'b0;
            wait_done(d0);
        end

        // randomized transfers, some with inputs changing and escribir held
        for (int n = 0; n < 4; n++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            xfer(n[0]);
        end

        // reset during item 4 data-phase wr pulse
        begin
            int t, base;
            base = dphase_cnt;
            seg = rbcd(); min = rbcd(); hora = rbcd(); dia = rbcd(); mes = rbcd();
            anio = rbcd(); tseg = rbcd(); tmin = rbcd(); thora = rbcd();
            issue_start();
            escribir = 1'b0;
            t = 0;
            while (dphase_cnt < base + 5 && t < 6 * TX) begin
                @(negedge clk);
                t++;
            end
            if (dphase_cnt < base + 5) begin
                checks++; failures++;
                $display("FAIL timeout_item4 got=%0d exp=%0d", dphase_cnt - base, 5);
            end
            #1 reset = 1'b1;
            #1;
            checks++;
            if ({wr, cs, a_d, buffer_activo, ocupado, ready, dato_out} !== {3'b111, 3'b000, 8'h00}) begin
                failures++;
                $display("FAIL async_reset got=%b%b%b%b%b%b/%02h exp=111000/00",
                         wr, cs, a_d, buffer_activo, ocupado, ready, dato_out);
            end
            exp_q.delete();
            rdy_q.delete();
            first_wr_exp = -1;
            repeat (2) @(negedge clk);
            reset = 1'b0;
            xfer(1'b0);
        end

        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || rdy_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_expected got=%0d/%0d exp=0/0", exp_q.size(), rdy_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
